// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and defaults for the HUB75 slice scheduler.
//   sched_state_t : sequencer states
//   SCAN_W        : scan address width for the default scan rate
//   MEM_ADDR_W    : {theta, scan_addr, half} frame-buffer address width
//   rgb_pix_t     : one pixel at the default colour depth
//   tp_pixel()    : base 9-bit test-pattern pixel
package hub75_pkg;

  localparam int unsigned HUB75_NUM_ROWS    = 64;
  localparam int unsigned HUB75_SCAN_RATE   = 32;
  localparam int unsigned HUB75_THETA_RES   = 8;
  localparam int unsigned HUB75_RGB_RES     = 9;
  localparam int unsigned HUB75_MEM_LATENCY = 2;

  localparam int unsigned SCAN_W     = $clog2(HUB75_SCAN_RATE);
  localparam int unsigned MEM_ADDR_W = HUB75_THETA_RES + SCAN_W + 1;

  typedef logic [HUB75_RGB_RES-1:0] rgb_pix_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_TOP,
    ST_FETCH_BOT,
    ST_WAIT_DATA,
    ST_PRESENT
  } sched_state_t;

  // {theta[2:0], scan[2:0], half, row[1:0]}; the caller resizes to its pixel depth
  function automatic logic [8:0] tp_pixel(input logic [2:0] theta_lsb,
                                          input logic [2:0] scan_lsb,
                                          input logic       half,
                                          input logic [1:0] row_lsb);
    return {theta_lsb, scan_lsb, half, row_lsb};
  endfunction

endpackage

// File: rtl/hub75_rd_tracker.sv
// hub75_rd_tracker: fixed-latency tracker for outstanding frame-buffer reads.
//   clk_in, rst_in : clock, async active-high reset
//   rd, half       : read issued this cycle and which half-column it targets
//   cap_valid      : mem_rdata holds the data of a read issued MEM_LATENCY ago
//   cap_half       : half-column that data belongs to
module hub75_rd_tracker
  import hub75_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = HUB75_MEM_LATENCY
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rd,
  input  logic half,
  output logic cap_valid,
  output logic cap_half
);

  logic [MEM_LATENCY-1:0] rd_sr;
  logic [MEM_LATENCY-1:0] half_sr;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_sr   <= '0;
      half_sr <= '0;
    end else begin
      rd_sr[0]   <= rd;
      half_sr[0] <= half;
      for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
        rd_sr[i]   <= rd_sr[i-1];
        half_sr[i] <= half_sr[i-1];
      end
    end
  end

  assign cap_valid = rd_sr[MEM_LATENCY-1];
  assign cap_half  = half_sr[MEM_LATENCY-1];

endmodule

// File: rtl/hub75_slice_scheduler.sv
// hub75_slice_scheduler: per-slice sequencer between the frame-buffer BRAM and
// the HUB75 driver. Each slice strobe walks scan addresses 0..SCAN_RATE-1,
// fetches top and bottom half-columns and presents them over valid/ready.
//   clk_in, rst_in        : clock, async active-high reset
//   enable                : accept new slice strobes
//   slice_strobe/_theta   : new slice request and its angle index
//   mem_rd/mem_addr       : frame-buffer read, address {theta, scan_addr, half}
//   mem_rdata             : read data, MEM_LATENCY cycles after mem_rd
//   column_data           : [0]=top half, [1]=bottom half
//   address_data          : scan address of column_data
//   tvalid/tready         : driver handshake
//   busy                  : slice in progress
//   overrun_count         : saturating count of dropped strobes
// Build option: HUB75_TEST_PATTERN_EN replaces mem_rdata with a generated
// pattern; read timing and addressing are unchanged.
module hub75_slice_scheduler
  import hub75_pkg::*;
#(
  parameter int unsigned NUM_ROWS    = HUB75_NUM_ROWS,
  parameter int unsigned SCAN_RATE   = HUB75_SCAN_RATE,
  parameter int unsigned THETA_RES   = HUB75_THETA_RES,
  parameter int unsigned RGB_RES     = HUB75_RGB_RES,
  parameter int unsigned MEM_LATENCY = HUB75_MEM_LATENCY
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic                                       enable,
  input  logic                                       slice_strobe,
  input  logic [THETA_RES-1:0]                       slice_theta,
  output logic                                       mem_rd,
  output logic [THETA_RES+$clog2(SCAN_RATE):0]       mem_addr,
  input  logic [NUM_ROWS*RGB_RES-1:0]                mem_rdata,
  output logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]      column_data,
  output logic [$clog2(SCAN_RATE)-1:0]               address_data,
  output logic                                       tvalid,
  input  logic                                       tready,
  output logic                                       busy,
  output logic [7:0]                                 overrun_count
);

  localparam int unsigned           SCAN_BITS = $clog2(SCAN_RATE);
  localparam logic [SCAN_BITS-1:0]  LAST_SCAN = SCAN_BITS'(SCAN_RATE - 1);

  sched_state_t            state;
  logic [THETA_RES-1:0]    cur_theta;
  logic [THETA_RES-1:0]    pend_theta;
  logic                    pending;
  logic [SCAN_BITS-1:0]    scan_addr;
  logic [SCAN_BITS-1:0]    next_scan;
  logic                    cap_valid;
  logic                    cap_half;
  logic [NUM_ROWS*RGB_RES-1:0] cap_word;
  logic                    strobe_ok;
  logic                    slice_end;
  logic                    start_now;
  logic [THETA_RES-1:0]    start_theta;

  hub75_rd_tracker #(
    .MEM_LATENCY(MEM_LATENCY)
  ) u_rd_tracker (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rd        (mem_rd),
    .half      (mem_addr[0]),
    .cap_valid (cap_valid),
    .cap_half  (cap_half)
  );

`ifdef HUB75_TEST_PATTERN_EN
  always_comb begin
    cap_word = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      cap_word[r*RGB_RES +: RGB_RES] =
        RGB_RES'(tp_pixel(cur_theta[2:0], scan_addr[2:0], cap_half, 2'(r)));
    end
  end
`else
  assign cap_word = mem_rdata;
`endif

  assign next_scan   = scan_addr + SCAN_BITS'(1);
  assign strobe_ok   = slice_strobe && enable;
  assign slice_end   = (state == ST_PRESENT) && tready && (scan_addr == LAST_SCAN);
  // a strobe landing on the final transfer starts the next slice directly,
  // otherwise a queued pending slice follows without passing through IDLE
  assign start_now   = (strobe_ok && (state == ST_IDLE)) ||
                       (slice_end && (strobe_ok || pending));
  assign start_theta = strobe_ok ? slice_theta : pend_theta;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= ST_IDLE;
      cur_theta     <= '0;
      pend_theta    <= '0;
      pending       <= 1'b0;
      scan_addr     <= '0;
      mem_rd        <= 1'b0;
      mem_addr      <= '0;
      column_data   <= '0;
      address_data  <= '0;
      tvalid        <= 1'b0;
      busy          <= 1'b0;
      overrun_count <= '0;
    end else begin
      if (cap_valid) column_data[cap_half] <= cap_word;

      unique case (state)
        ST_IDLE: ;
        ST_FETCH_TOP: begin
          mem_rd   <= 1'b1;
          mem_addr <= {cur_theta, scan_addr, 1'b1};
          state    <= ST_FETCH_BOT;
        end
        ST_FETCH_BOT: begin
          mem_rd <= 1'b0;
          state  <= ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
          if (cap_valid && cap_half) begin
            tvalid       <= 1'b1;
            address_data <= scan_addr;
            state        <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (tready) begin
            tvalid <= 1'b0;
            if (scan_addr == LAST_SCAN) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              scan_addr <= next_scan;
              mem_rd    <= 1'b1;
              mem_addr  <= {cur_theta, next_scan, 1'b0};
              state     <= ST_FETCH_TOP;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (strobe_ok && (state != ST_IDLE)) begin
        pending <= !slice_end;
        if (!slice_end) pend_theta <= slice_theta;
        if (pending && (overrun_count != 8'hFF)) overrun_count <= overrun_count + 8'd1;
      end else if (slice_end) begin
        pending <= 1'b0;
      end

      // overrides the slice-end IDLE transition above
      if (start_now) begin
        cur_theta <= start_theta;
        scan_addr <= '0;
        mem_rd    <= 1'b1;
        mem_addr  <= {start_theta, {SCAN_BITS{1'b0}}, 1'b0};
        state     <= ST_FETCH_TOP;
        busy      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hub75_slice_scheduler.sv
module tb_hub75_slice_scheduler;

  localparam int unsigned NR = 64;
  localparam int unsigned SR = 32;
  localparam int unsigned TR = 8;
  localparam int unsigned RR = 9;
  localparam int unsigned ML = 2;
  localparam int unsigned SW = 5;
  localparam int unsigned AW = TR + SW + 1;
  localparam int unsigned WW = NR * RR;

  logic                          clk_in = 1'b0;
  logic                          rst_in = 1'b0;
  logic                          enable = 1'b1;
  logic                          slice_strobe = 1'b0;
  logic [TR-1:0]                 slice_theta = '0;
  logic                          mem_rd;
  logic [AW-1:0]                 mem_addr;
  logic [WW-1:0]                 mem_rdata;
  logic [1:0][NR-1:0][RR-1:0]    column_data;
  logic [SW-1:0]                 address_data;
  logic                          tvalid;
  logic                          tready = 1'b1;
  logic                          busy;
  logic [7:0]                    overrun_count;

  always #5 clk_in = ~clk_in;

  hub75_slice_scheduler #(
    .NUM_ROWS(NR), .SCAN_RATE(SR), .THETA_RES(TR), .RGB_RES(RR), .MEM_LATENCY(ML)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable(enable), .slice_strobe(slice_strobe),
    .slice_theta(slice_theta), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .column_data(column_data), .address_data(address_data),
    .tvalid(tvalid), .tready(tready), .busy(busy), .overrun_count(overrun_count)
  );

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned seed     = 0;
  int unsigned n_xfer   = 0;

  // frame buffer content: pseudo-random word per address
  function automatic logic [WW-1:0] mk_word(input logic [AW-1:0] a, input int unsigned s);
    logic [WW-1:0] w;
    int unsigned x;
    for (int k = 0; k < int'(WW / 32); k++) begin
      x = ((32'(a) + 32'd1) * 32'h9E3779B1) ^ s ^ (32'(k) * 32'h85EBCA6B);
      x = x ^ (x >> 15);
      x = x * 32'h2C1B3C6D;
      x = x ^ (x >> 13);
      w[k*32 +: 32] = x;
    end
    return w;
  endfunction

  // memory with fixed read latency ML; garbage when no read is returning
  logic [ML-1:0] pv = '0;
  logic [AW-1:0] pa [ML];
  always @(posedge clk_in) begin
    pv[0] <= mem_rd;
    pa[0] <= mem_addr;
    for (int i = 1; i < int'(ML); i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign mem_rdata = (pv[ML-1] === 1'b1) ? mk_word(pa[ML-1], seed)
                                         : ~mk_word(pa[ML-1] ^ AW'(1), seed);

  function automatic logic [WW-1:0] exp_col(input logic [TR-1:0] th, input logic [SW-1:0] a,
                                            input logic h);
    logic [WW-1:0] w;
`ifdef HUB75_TEST_PATTERN_EN
    int unsigned v;
    for (int r = 0; r < int'(NR); r++) begin
      v = (int'(th) % 8) * 64 + (int'(a) % 8) * 8 + int'(h) * 4 + (r % 4);
      w[r*RR +: RR] = RR'(v);
    end
`else
    w = mk_word({th, a, h}, seed);
`endif
    return w;
  endfunction

  // behavioural model: expected transfers and reads, pending slice, overruns
  typedef struct { logic [TR-1:0] th; logic [SW-1:0] a; } xfer_t;
  xfer_t          tq[$];
  logic [AW-1:0]  rq[$];
  bit             m_pending = 0;
  logic [TR-1:0]  m_ptheta  = '0;
  int unsigned    m_ov      = 0;
  bit             m_busy    = 0;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_slice(input logic [TR-1:0] t);
    for (int a = 0; a < int'(SR); a++) begin
      tq.push_back('{th: t, a: SW'(a)});
      rq.push_back({t, SW'(a), 1'b0});
      rq.push_back({t, SW'(a), 1'b1});
    end
  endtask

  task automatic ov_inc();
    if (m_ov < 255) m_ov++;
  endtask

  // one clock: account for the handshake/strobe about to be sampled, then check
  task automatic step();
    bit xfer, end_s, stall;
    xfer_t e;
    logic [SW-1:0] s_addr;
    logic [1:0][NR-1:0][RR-1:0] s_col;
    xfer   = (tvalid === 1'b1) && (tready === 1'b1) && !rst_in;
    stall  = (tvalid === 1'b1) && !tready && !rst_in;
    end_s  = 0;
    s_addr = address_data;
    s_col  = column_data;
    if (xfer) begin
      chk("xfer_expected", WW'(tq.size() != 0), WW'(1));
      if (tq.size() != 0) begin
        e = tq.pop_front();
        n_xfer++;
        chk("address_data", WW'(address_data), WW'(e.a));
        chk("col_top", column_data[0], exp_col(e.th, e.a, 1'b0));
        chk("col_bot", column_data[1], exp_col(e.th, e.a, 1'b1));
        end_s = (tq.size() == 0);
      end
    end
    if (!rst_in) begin
      if (slice_strobe && enable) begin
        if (!m_busy || end_s) begin
          if (m_pending) begin ov_inc(); m_pending = 0; end
          start_slice(slice_theta);
        end else begin
          if (m_pending) ov_inc();
          m_pending = 1;
          m_ptheta  = slice_theta;
        end
      end else if (end_s && m_pending) begin
        m_pending = 0;
        start_slice(m_ptheta);
      end
    end
    m_busy = (tq.size() != 0);
    @(posedge clk_in);
    @(negedge clk_in);
    chk("busy", WW'(busy), WW'(m_busy));
    chk("overrun_count", WW'(overrun_count), WW'(m_ov));
    chk("tvalid_with_mem_rd", WW'(tvalid && mem_rd), WW'(0));
    if (xfer) begin
      chk("tvalid_drop", WW'(tvalid), WW'(0));
      chk("fetch_after_xfer", WW'(mem_rd), WW'(m_busy));
    end
    if (stall) begin
      chk("stall_tvalid", WW'(tvalid), WW'(1));
      chk("stall_addr", WW'(address_data), WW'(s_addr));
      chk("stall_col_top", column_data[0], s_col[0]);
      chk("stall_col_bot", column_data[1], s_col[1]);
    end
    if (mem_rd === 1'b1) begin
      chk("rd_expected", WW'(rq.size() != 0), WW'(1));
      if (rq.size() != 0) chk("mem_addr", WW'(mem_addr), WW'(rq.pop_front()));
    end
  endtask

  task automatic drain(input int budget, input bit rnd);
    int n = 0;
    while ((m_busy || busy) && n < budget) begin
      tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
      n++;
    end
    tready = 1'b1;
    chk("drain_timeout", WW'(n < budget), WW'(1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, hold, n;
    bit found;
    seed = $urandom;

    // reset state
    #1 rst_in = 1'b1;
    #1;
    chk("rst_tvalid", WW'(tvalid), WW'(0));
    chk("rst_mem_rd", WW'(mem_rd), WW'(0));
    chk("rst_busy", WW'(busy), WW'(0));
    chk("rst_overrun", WW'(overrun_count), WW'(0));
    chk("rst_addr", WW'(address_data), WW'(0));
    chk("rst_mem_addr", WW'(mem_addr), WW'(0));
    chk("rst_col_top", column_data[0], WW'(0));
    chk("rst_col_bot", column_data[1], WW'(0));
    @(negedge clk_in);
    step();
    rst_in = 1'b0;
    step();

    // single slice, theta 0x05, tready high
    n_xfer = 0;
    slice_theta = 8'h05; slice_strobe = 1'b1;
    step();
    slice_strobe = 1'b0;
    k = 1;
    while (tvalid !== 1'b1 && k < 40) begin step(); k++; end
    chk("first_tvalid_latency", WW'(k), WW'(3 + ML));
    drain(1000, 0);
    chk("slice_xfers", WW'(n_xfer), WW'(SR));

    // back-pressure for 10 cycles at address 3
    slice_theta = 8'($urandom); slice_strobe = 1'b1;
    step();
    slice_strobe = 1'b0;
    hold = 0; n = 0;
    while ((m_busy || busy) && n < 1000) begin
      if (tvalid === 1'b1 && address_data == 3 && hold < 10) begin
        tready = 1'b0; hold++;
      end else tready = 1'b1;
      step();
      n++;
    end
    tready = 1'b1;
    chk("stall_cycles", WW'(hold), WW'(10));

    // strobes 1,2,3 during one slice: slice 3 follows directly, one overrun
    slice_theta = 8'd1; slice_strobe = 1'b1; step();
    slice_strobe = 1'b0; step(); step(); step();
    slice_theta = 8'd2; slice_strobe = 1'b1; step();
    slice_strobe = 1'b0; step();
    slice_theta = 8'd3; slice_strobe = 1'b1; step();
    slice_strobe = 1'b0;
    drain(2000, 0);
    chk("overrun_one", WW'(overrun_count), WW'(1));

    // continuous strobing: overrun count saturates
    for (int i = 0; i < 330; i++) begin
      slice_theta  = 8'($urandom);
      slice_strobe = !(tvalid === 1'b1 && address_data == SW'(SR - 1));
      step();
    end
    slice_strobe = 1'b0;
    drain(2000, 0);
    chk("overrun_sat", WW'(overrun_count), WW'(255));

    // reset in the middle of presenting address 17
    slice_theta = 8'($urandom); slice_strobe = 1'b1; step();
    slice_strobe = 1'b0;
    found = 0; n = 0;
    while (!found && n < 1000) begin
      if (tvalid === 1'b1 && address_data == 17) found = 1;
      else begin step(); n++; end
    end
    chk("reached_addr17", WW'(found), WW'(1));
    rst_in = 1'b1;
    #1;
    chk("midrst_tvalid", WW'(tvalid), WW'(0));
    chk("midrst_mem_rd", WW'(mem_rd), WW'(0));
    chk("midrst_busy", WW'(busy), WW'(0));
    chk("midrst_overrun", WW'(overrun_count), WW'(0));
    tq.delete(); rq.delete();
    m_pending = 0; m_ov = 0; m_busy = 0;
    @(negedge clk_in);
    step();
    rst_in = 1'b0;
    step();
    slice_theta = 8'($urandom); slice_strobe = 1'b1; step();
    slice_strobe = 1'b0;
    drain(2000, 1);

    // disabled strobe is ignored
    enable = 1'b0;
    slice_theta = 8'($urandom); slice_strobe = 1'b1; step();
    slice_strobe = 1'b0;
    step(); step(); step();
    chk("disabled_busy", WW'(busy), WW'(0));
    chk("disabled_mem_rd", WW'(mem_rd), WW'(0));
    enable = 1'b1;

`ifdef HUB75_TEST_PATTERN_EN
    slice_theta = 8'h06; slice_strobe = 1'b1; step();
    slice_strobe = 1'b0;
    found = 0; n = 0;
    while (!found && n < 1000) begin
      if (tvalid === 1'b1 && address_data == 2) found = 1;
      else begin step(); n++; end
    end
    chk("tp_reached_addr2", WW'(found), WW'(1));
    chk("tp_pixel_bot0", WW'(column_data[1][0]), WW'(9'b110_010_1_00));
    drain(2000, 0);
`endif

    // random traffic: random tready, enable and strobes
    for (int i = 0; i < 1500; i++) begin
      tready       = ($urandom_range(0, 3) != 0);
      enable       = ($urandom_range(0, 7) != 0);
      slice_theta  = 8'($urandom);
      slice_strobe = ($urandom_range(0, 39) == 0) &&
                     !(m_pending && tvalid === 1'b1 && tready && address_data == SW'(SR - 1));
      step();
    end
    slice_strobe = 1'b0;
    enable = 1'b1;
    drain(4000, 1);
    chk("final_idle_busy", WW'(busy), WW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
